// File: rtl/led_cursor_ctrl.sv
// led_cursor_ctrl: three-button cursor mover for an LED_W-wide LED bank.
// Each raw button is synchronised and debounced. Press edges step the
// cursor, and a held direction button auto-repeats. Centre press recentres.
// Optional build macro BAR_MODE_EN: led shows a thermometer bar (bits 0..pos)
// instead of a one-hot cursor. pos, moved and hit_edge are the same in both.
// dbg_state exposes the auto-repeat FSM state (0 = IDLE, 1 = HOLD, 2 = REPEAT).
module led_cursor_ctrl #(
    parameter int LED_W        = 8,
    parameter int DEB_CYCLES   = 1000000,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int WRAP         = 0,
    localparam int POS_W       = $clog2(LED_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_center,
    output logic [LED_W-1:0] led,
    output logic [POS_W-1:0] pos,
    output logic             moved,
    output logic             hit_edge,
    output logic [1:0]       dbg_state
);

    localparam int CENTER    = LED_W / 2;
    localparam int DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TMAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW        = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int HOLD_LAST = (REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0;
    localparam int RATE_LAST = REPEAT_RATE - 1;
    localparam int CH_L      = 0;
    localparam int CH_R      = 1;
    localparam int CH_C      = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_q;
    logic [2:0]    press;
    logic [DW-1:0] cnt [3];

    state_t        state;
    state_t        state_n;
    logic          dir_left;
    logic          dir_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic          step;
    logic          step_left;
    logic          held;

    assign raw       = {btn_center, btn_right, btn_left};
    assign press     = deb & ~deb_q;
    assign held      = dir_left ? deb[CH_L] : deb[CH_R];
    assign dbg_state = state;

    // Synchronise each button, then flip its debounced level only after
    // DEB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            for (int ch = 0; ch < 3; ch++) cnt[ch] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int ch = 0; ch < 3; ch++) begin
                if (sync2[ch] == deb[ch]) begin
                    cnt[ch] <= '0;
                end else if (cnt[ch] == DW'(DEB_CYCLES - 1)) begin
                    deb[ch] <= sync2[ch];
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + 1'b1;
                end
            end
        end
    end

    // Auto-repeat FSM state, latched direction and hold/repeat timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir_left <= 1'b0;
            timer    <= '0;
        end else begin
            state    <= state_n;
            dir_left <= dir_n;
            timer    <= timer_n;
        end
    end

    // Next-state logic: centre press and both-directions-held abort to IDLE
    // before any step is considered.
    always_comb begin
        state_n   = state;
        dir_n     = dir_left;
        timer_n   = timer;
        step      = 1'b0;
        step_left = dir_left;
        if (press[CH_C]) begin
            state_n = IDLE;
            timer_n = '0;
        end else if (deb[CH_L] && deb[CH_R]) begin
            state_n = IDLE;
            timer_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press[CH_L] || press[CH_R]) begin
                        step      = 1'b1;
                        step_left = press[CH_L];
                        dir_n     = press[CH_L];
                        timer_n   = '0;
                        state_n   = (REPEAT_DELAY == 0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    if (!held) begin
                        state_n = IDLE;
                    end else if (timer == TW'(HOLD_LAST)) begin
                        step    = 1'b1;
                        timer_n = '0;
                        state_n = REPEAT;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held) begin
                        state_n = IDLE;
                    end else if (timer == TW'(RATE_LAST)) begin
                        step    = 1'b1;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Cursor register: recentre beats stepping; ends saturate or wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos      <= POS_W'(CENTER);
            moved    <= 1'b0;
            hit_edge <= 1'b0;
        end else begin
            moved    <= 1'b0;
            hit_edge <= 1'b0;
            if (press[CH_C]) begin
                if (pos != POS_W'(CENTER)) begin
                    pos   <= POS_W'(CENTER);
                    moved <= 1'b1;
                end
            end else if (step) begin
                if (step_left) begin
                    if (pos == POS_W'(LED_W - 1)) begin
                        if (WRAP != 0) begin
                            pos   <= '0;
                            moved <= 1'b1;
                        end else begin
                            hit_edge <= 1'b1;
                        end
                    end else begin
                        pos   <= pos + 1'b1;
                        moved <= 1'b1;
                    end
                end else begin
                    if (pos == '0) begin
                        if (WRAP != 0) begin
                            pos   <= POS_W'(LED_W - 1);
                            moved <= 1'b1;
                        end else begin
                            hit_edge <= 1'b1;
                        end
                    end else begin
                        pos   <= pos - 1'b1;
                        moved <= 1'b1;
                    end
                end
            end
        end
    end

    // LED decode straight from the pos register.
    always_comb begin
        led = '0;
        for (int i = 0; i < LED_W; i++) begin
`ifdef BAR_MODE_EN
            led[i] = (i <= int'(pos));
`else
            led[i] = (i == int'(pos));
`endif
        end
    end

endmodule

// File: tb/tb_led_cursor_ctrl.sv
// Bench for led_cursor_ctrl: three instances (8 LEDs saturating, 8 LEDs
// wrapping, 5 LEDs wrapping) share one set of button inputs.
module tb_led_cursor_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RR  = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_l = 1'b0;
  logic btn_r = 1'b0;
  logic btn_c = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] led0, led1;
  logic [4:0] led2;
  logic [2:0] pos0, pos1, pos2;
  logic       moved0, moved1, moved2;
  logic       hit0, hit1, hit2;
  logic [1:0] st0, st1, st2;

  led_cursor_ctrl #(.LED_W(8), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_l), .btn_right(btn_r), .btn_center(btn_c),
    .led(led0), .pos(pos0), .moved(moved0), .hit_edge(hit0), .dbg_state(st0));
  led_cursor_ctrl #(.LED_W(8), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_l), .btn_right(btn_r), .btn_center(btn_c),
    .led(led1), .pos(pos1), .moved(moved1), .hit_edge(hit1), .dbg_state(st1));
  led_cursor_ctrl #(.LED_W(5), .DEB_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .btn_left(btn_l), .btn_right(btn_r), .btn_center(btn_c),
    .led(led2), .pos(pos2), .moved(moved2), .hit_edge(hit2), .dbg_state(st2));

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] exp_led(input int p, input int w);
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < w; k++) begin
`ifdef BAR_MODE_EN
      v[k] = (k <= p);
`else
      v[k] = (k == p);
`endif
    end
    return v;
  endfunction

  // ---------------- reference model ----------------
  // Debounce: a level flips once the last DEB synchronised samples (raw
  // samples from two edges earlier) all disagree with it. Auto-repeat: after
  // the first step at edge t0, steps fall at t0+RD, t0+RD+RR, ... while held.
  int  lw [3] = '{8, 8, 5};
  int  wr [3] = '{0, 1, 1};
  int  m_pos [3];
  bit  m_moved [3];
  bit  m_hit [3];
  bit  hist [3][0:DEB];
  bit  dcur [3];
  bit  dprev [3];
  bit  active;
  bit  adir_left;
  int  t0;
  int  cyc = 0;

  always @(posedge clk) begin
    bit pr [3];
    bit do_step;
    bit sl;
    bit flip;
    bit rawv [3];
    int e;
    rawv[0] = btn_l; rawv[1] = btn_r; rawv[2] = btn_c;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_pos[i] = lw[i] / 2; m_moved[i] = 0; m_hit[i] = 0;
        dcur[i] = 0; dprev[i] = 0;
        for (int j = 0; j <= DEB; j++) hist[i][j] = 0;
      end
      active = 0;
    end else begin
      for (int ch = 0; ch < 3; ch++) pr[ch] = dcur[ch] && !dprev[ch];
      do_step = 0; sl = 0;
      if (pr[2]) active = 0;
      else if (dcur[0] && dcur[1]) active = 0;
      else if (active) begin
        if (!(adir_left ? dcur[0] : dcur[1])) active = 0;
        else begin
          e = cyc - t0;
          if (e >= RD && ((e - RD) % RR) == 0) begin do_step = 1; sl = adir_left; end
        end
      end else if (pr[0] || pr[1]) begin
        do_step = 1; sl = pr[0];
        if (RD > 0) begin active = 1; adir_left = pr[0]; t0 = cyc; end
      end
      for (int i = 0; i < 3; i++) begin
        m_moved[i] = 0; m_hit[i] = 0;
        if (pr[2]) begin
          if (m_pos[i] != lw[i] / 2) begin m_pos[i] = lw[i] / 2; m_moved[i] = 1; end
        end else if (do_step) begin
          if (wr[i] != 0) begin
            m_pos[i] = sl ? (m_pos[i] + 1) % lw[i] : (m_pos[i] + lw[i] - 1) % lw[i];
            m_moved[i] = 1;
          end else if ((sl && m_pos[i] == lw[i] - 1) || (!sl && m_pos[i] == 0)) begin
            m_hit[i] = 1;
          end else begin
            m_pos[i] = sl ? m_pos[i] + 1 : m_pos[i] - 1;
            m_moved[i] = 1;
          end
        end
      end
      for (int ch = 0; ch < 3; ch++) begin
        flip = 1;
        for (int j = 1; j <= DEB; j++) if (hist[ch][j] == dcur[ch]) flip = 0;
        dprev[ch] = dcur[ch];
        if (flip) dcur[ch] = !dcur[ch];
        for (int j = DEB; j >= 1; j--) hist[ch][j] = hist[ch][j-1];
        hist[ch][0] = rawv[ch];
      end
    end
    #1;
    chk("model_pos0", 32'(pos0), 32'(m_pos[0]));
    chk("model_led0", 32'(led0), 32'(exp_led(m_pos[0], 8)));
    chk("model_moved0", 32'(moved0), 32'(m_moved[0]));
    chk("model_hit0", 32'(hit0), 32'(m_hit[0]));
    chk("model_pos1", 32'(pos1), 32'(m_pos[1]));
    chk("model_led1", 32'(led1), 32'(exp_led(m_pos[1], 8)));
    chk("model_moved1", 32'(moved1), 32'(m_moved[1]));
    chk("model_hit1", 32'(hit1), 32'(m_hit[1]));
    chk("model_pos2", 32'(pos2), 32'(m_pos[2]));
    chk("model_led2", 32'({3'b000, led2}), 32'(exp_led(m_pos[2], 5)));
    chk("model_moved2", 32'(moved2), 32'(m_moved[2]));
    chk("model_hit2", 32'(hit2), 32'(m_hit[2]));
  end

  // ---------------- driver tasks ----------------
  task automatic press(input bit l, input bit r, input bit c, input int n_on, input int n_after);
    @(negedge clk);
    btn_l = l; btn_r = r; btn_c = c;
    repeat (n_on) @(negedge clk);
    btn_l = 0; btn_r = 0; btn_c = 0;
    repeat (n_after) @(negedge clk);
  endtask

  typedef struct {
    bit l; bit r; bit c;
    int n_on;
    int p0; int p1; int p2;
  } vec_t;

  vec_t tbl [13];
  bit   glitch [13];

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rst_led;
    // stimulus table: {left, right, centre, held cycles, expected pos per DUT}
    tbl[0]  = '{1, 0, 0, 3,  4, 4, 2};  // too short to debounce
    tbl[1]  = '{1, 0, 0, 8,  5, 5, 3};  // single step, no repeat
    tbl[2]  = '{0, 1, 0, 8,  4, 4, 2};
    tbl[3]  = '{1, 0, 0, 30, 7, 7, 0};  // three steps, wrap on dut2
    tbl[4]  = '{1, 0, 0, 30, 7, 2, 3};  // saturated on dut0
    tbl[5]  = '{0, 0, 1, 8,  4, 4, 2};
    tbl[6]  = '{0, 1, 0, 30, 1, 1, 4};
    tbl[7]  = '{0, 1, 0, 30, 0, 6, 1};
    tbl[8]  = '{1, 1, 0, 10, 0, 6, 1};  // both together: no step
    tbl[9]  = '{0, 0, 1, 8,  4, 4, 2};
    tbl[10] = '{0, 0, 1, 8,  4, 4, 2};  // already centred
    tbl[11] = '{1, 0, 1, 8,  4, 4, 2};  // centre beats left
    tbl[12] = '{1, 0, 0, 3,  4, 4, 2};
    glitch = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0};
`ifdef BAR_MODE_EN
    rst_led = 8'h1F;
`else
    rst_led = 8'h10;
`endif

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pos", 32'(pos0), 32'd4);
    chk("reset_led", 32'(led0), 32'(rst_led));
    chk("reset_moved", 32'(moved0), 32'd0);
    chk("reset_hit", 32'(hit0), 32'd0);
    chk("reset_state", 32'(st0), 32'd0);
    chk("reset_pos_w5", 32'(pos2), 32'd2);

    // glitch train, no run of 4 samples
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      btn_l = glitch[i];
    end
    @(negedge clk);
    btn_l = 0;
    repeat (12) @(negedge clk);
    chk("glitch_pos0", 32'(pos0), 32'd4);
    chk("glitch_pos2", 32'(pos2), 32'd2);

    // table-driven directed vectors
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].n_on, 12);
      chk($sformatf("tbl%0d_pos0", i), 32'(pos0), 32'(tbl[i].p0));
      chk($sformatf("tbl%0d_pos1", i), 32'(pos1), 32'(tbl[i].p1));
      chk($sformatf("tbl%0d_pos2", i), 32'(pos2), 32'(tbl[i].p2));
    end

    // long hold from centre: exact step timing and edge hits on dut0
    @(negedge clk);
    btn_l = 1;
    repeat (7) @(posedge clk);
    #1 chk("hold_first_pos", 32'(pos0), 32'd5);
    chk("hold_first_moved", 32'(moved0), 32'd1);
    repeat (19) @(posedge clk);
    #1 chk("hold_wait_pos", 32'(pos0), 32'd5);
    @(posedge clk);
    #1 chk("hold_delay_pos", 32'(pos0), 32'd6);
    repeat (5) @(posedge clk);
    #1 chk("hold_rate_pos", 32'(pos0), 32'd7);
    repeat (5) @(posedge clk);
    #1 chk("hold_edge_hit", 32'(hit0), 32'd1);
    chk("hold_edge_pos", 32'(pos0), 32'd7);
    chk("hold_edge_moved", 32'(moved0), 32'd0);
    @(posedge clk);
    #1 chk("hold_edge_hit_clr", 32'(hit0), 32'd0);
    repeat (4) @(posedge clk);
    #1 chk("hold_edge_hit2", 32'(hit0), 32'd1);
    @(negedge clk);
    btn_l = 0;
    repeat (12) @(negedge clk);

    // reset in the middle of REPEAT with left still held
    press(0, 0, 1, 8, 12);
    @(negedge clk);
    btn_l = 1;
    repeat (27) @(posedge clk);
    #1 chk("mid_repeat_pos", 32'(pos0), 32'd6);
    chk("mid_repeat_state", 32'(st0), 32'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("async_rst_pos", 32'(pos0), 32'd4);
    chk("async_rst_state", 32'(st0), 32'd0);
    chk("async_rst_led", 32'(led0), 32'(rst_led));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("rerelease_wait_pos", 32'(pos0), 32'd4);
    @(posedge clk);
    #1 chk("rerelease_step_pos", 32'(pos0), 32'd5);
    chk("rerelease_moved", 32'(moved0), 32'd1);
    @(negedge clk);
    btn_l = 0;
    repeat (12) @(negedge clk);

    // randomized traffic, checked cycle by cycle against the model
    for (int s = 0; s < 70; s++) begin
      bit l, r, c;
      l = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      c = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
      if (s == 35) begin
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      press(l, r, c, $urandom_range(1, 45), $urandom_range(0, 15));
    end
    repeat (15) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
